mp64_tile_row_dma: RTL

//  Port-A initiator for mp64_sram_dp; the 512b port is the tile side, the 64b port is the CPU side.
//  - Read command: fetches whole 512b rows, streams them out as 64b beats (valid/ready).
//  - Write command: gathers 64b beats into a row, then commits the row with one wide write.
//  - Beat order matches port-B addressing {row, w}: beat w = row bits [w*64 +: 64], w=0 first.

---
 rtl/mp64_tile_row_dma.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mp64_tile_row_dma.sv
// Row DMA for the port-A side of mp64_sram_dp: streams 512b rows out as 64b beats, gathers beats into rows.
// Optional stall counter enabled by defining MP64_ROWDMA_STALL_CNT_EN.
module mp64_tile_row_dma #(
    parameter int ADDR_W_A = 4,
    parameter int DATA_W_A = 512,
    parameter int DATA_W_B = 64,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W_A-1:0] cmd_row,
    input  logic [CNT_W-1:0]    cmd_count,
    output logic                busy,
    output logic                done,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [DATA_W_B-1:0] s_data,
    output logic                s_last,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [DATA_W_B-1:0] w_data,
    output logic                a_ce,
    output logic                a_we,
    output logic [ADDR_W_A-1:0] a_addr,
    output logic [DATA_W_A-1:0] a_wdata,
    input  logic [DATA_W_A-1:0] a_rdata,
    output logic [15:0]         stall_cnt
);

    localparam int WORDS = DATA_W_A / DATA_W_B;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_REQ    = 3'd1;
    localparam logic [2:0] S_RD_WAIT   = 3'd2;
    localparam logic [2:0] S_RD_SHIFT  = 3'd3;
    localparam logic [2:0] S_WR_FILL   = 3'd4;
    localparam logic [2:0] S_WR_COMMIT = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]                     r_state;
    logic [ADDR_W_A-1:0]            r_row;
    logic [CNT_W-1:0]               r_rem;
    logic [IDX_W-1:0]               r_idx;
    logic [WORDS-1:0][DATA_W_B-1:0] r_buf;

    logic w_cmd_acc;
    logic w_rd_hs;
    logic w_wr_hs;
    logic w_last_row;

    assign w_cmd_acc  = cmd_valid & cmd_ready;
    assign w_rd_hs    = s_valid & s_ready;
    assign w_wr_hs    = w_valid & w_ready;
    assign w_last_row = (r_rem == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_acc) begin
                        r_row <= cmd_row;
                        r_rem <= cmd_count;
                        r_idx <= '0;
                        if (cmd_count == '0)
                            r_state <= S_DONE;
                        else
                            r_state <= cmd_write ? S_WR_FILL : S_RD_REQ;
                    end
                end
                S_RD_REQ:  r_state <= S_RD_WAIT;
                // SRAM data is valid during this cycle, one cycle after the request edge
                S_RD_WAIT: begin
                    r_buf   <= a_rdata;
                    r_state <= S_RD_SHIFT;
                end
                S_RD_SHIFT: begin
                    if (w_rd_hs) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_row   <= r_row + 1'b1;
                            r_rem   <= r_rem - 1'b1;
                            r_state <= w_last_row ? S_DONE : S_RD_REQ;
                        end
                    end
                end
                S_WR_FILL: begin
                    if (w_wr_hs) begin
                        r_buf[r_idx] <= w_data;
                        r_idx        <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX)
                            r_state <= S_WR_COMMIT;
                    end
                end
                S_WR_COMMIT: begin
                    r_row   <= r_row + 1'b1;
                    r_rem   <= r_rem - 1'b1;
                    r_state <= w_last_row ? S_DONE : S_WR_FILL;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign s_valid   = (r_state == S_RD_SHIFT);
    assign s_data    = r_buf[r_idx];
    assign s_last    = s_valid & (r_idx == LAST_IDX) & w_last_row;
    assign w_ready   = (r_state == S_WR_FILL);
    assign a_ce      = (r_state == S_RD_REQ) | (r_state == S_WR_COMMIT);
    assign a_we      = (r_state == S_WR_COMMIT);
    assign a_addr    = r_row;
    assign a_wdata   = r_buf;

`ifdef MP64_ROWDMA_STALL_CNT_EN
    logic [15:0] r_stall;
    logic        w_stall;

    assign w_stall = (s_valid & ~s_ready) | (w_ready & ~w_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall <= '0;
        else if (w_cmd_acc)
            r_stall <= '0;
        else if (w_stall && (r_stall != '1))
            r_stall <= r_stall + 1'b1;
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

endmodule
